// File: rtl/start_sprite_renderer.sv
// rtl/start_sprite_renderer.sv - composites the magnified "start" sprite ROM over the background pixel stream
// Optional feature macro: START_BLINK_EN (frame-synchronous blink of the sprite).
module start_sprite_renderer #(
    parameter int          SPRITE_W     = 32,
    parameter int          SPRITE_H     = 16,
    parameter int          SCALE_SHIFT  = 2,
    parameter logic [11:0] KEY_COLOR    = 12'hFFF,
    parameter int          INIT_X       = 256,
    parameter int          INIT_Y       = 200,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic        pos_load,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    input  logic [11:0] bg_rgb,
    output logic [9:0]  rom_row,
    output logic [9:0]  rom_col,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic        sprite_on
);

    // Screen-space size of the magnified sprite.
    localparam logic [10:0] BOX_W      = 11'(SPRITE_W << SCALE_SHIFT);
    localparam logic [10:0] BOX_H      = 11'(SPRITE_H << SCALE_SHIFT);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [9:0]  cur_x, cur_y;
    logic [9:0]  pend_x, pend_y;
    logic        pend_valid;
    logic [10:0] dx, dy;
    logic        in_box;
    logic        in_box_d, video_on_d;
    logic [11:0] bg_rgb_d;
    logic        visible;

    // Position is staged and only committed at a frame boundary so a frame is never torn.
    // A load in the same cycle as frame_tick wins and waits for the next tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_x      <= 10'(INIT_X);
            cur_y      <= 10'(INIT_Y);
            pend_x     <= 10'(INIT_X);
            pend_y     <= 10'(INIT_Y);
            pend_valid <= 1'b0;
        end else if (pos_load) begin
            pend_x     <= pos_x;
            pend_y     <= pos_y;
            pend_valid <= 1'b1;
        end else if (frame_tick && pend_valid) begin
            cur_x      <= pend_x;
            cur_y      <= pend_y;
            pend_valid <= 1'b0;
        end
    end

    // Stage 0: sprite-relative offsets; a negative offset sets bit 10, so the left/top
    // neighbourhood never wraps into the box and the right/bottom edge is clipped by the raster.
    always_comb begin
        dx      = {1'b0, x} - {1'b0, cur_x};
        dy      = {1'b0, y} - {1'b0, cur_y};
        in_box  = video_on && !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
        rom_col = in_box ? (dx[9:0] >> SCALE_SHIFT) : 10'd0;
        rom_row = in_box ? (dy[9:0] >> SCALE_SHIFT) : 10'd0;
    end

    // Stage 1 delays the side-band so it lines up with the ROM's registered output,
    // and stage 2 selects sprite or background into the output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_box_d   <= 1'b0;
            video_on_d <= 1'b0;
            bg_rgb_d   <= 12'd0;
            rgb_out    <= 12'd0;
            sprite_on  <= 1'b0;
        end else begin
            in_box_d   <= in_box;
            video_on_d <= video_on;
            bg_rgb_d   <= bg_rgb;
            if (!video_on_d) begin
                rgb_out   <= 12'd0;
                sprite_on <= 1'b0;
            end else if (in_box_d && visible && (rom_color != KEY_COLOR)) begin
                rgb_out   <= rom_color;
                sprite_on <= 1'b1;
            end else begin
                rgb_out   <= bg_rgb_d;
                sprite_on <= 1'b0;
            end
        end
    end

`ifdef START_BLINK_EN
    logic [7:0] blink_cnt;

    // Blink phase changes only on frame_tick, so every frame is drawn wholly on or off.
    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt <= 8'd0;
            visible   <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= 8'd0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + 8'd1;
            end
        end
    end
`else
    logic unused_blink;

    // Without blinking the sprite is always shown.
    assign visible      = 1'b1;
    assign unused_blink = ^BLINK_LAST;
`endif

endmodule

// File: tb/tb_start_sprite_renderer.sv
// tb/tb_start_sprite_renderer.sv - scoreboard bench for start_sprite_renderer with default parameters
module tb_start_sprite_renderer;

    logic        clk = 1'b0;
    logic        reset;
    logic        video_on;
    logic [9:0]  x, y;
    logic        frame_tick;
    logic        pos_load;
    logic [9:0]  pos_x, pos_y;
    logic [11:0] bg_rgb;
    logic [9:0]  rom_row, rom_col;
    logic [11:0] rom_color;
    logic [11:0] rgb_out;
    logic        sprite_on;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        son;
    } exp_t;
    exp_t q[$];

    // Bench-side position model.
    int m_cx = 256, m_cy = 200, m_px = 256, m_py = 200;
    bit m_pv = 1'b0;

    start_sprite_renderer dut (
        .clk        (clk),
        .reset      (reset),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .pos_load   (pos_load),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .bg_rgb     (bg_rgb),
        .rom_row    (rom_row),
        .rom_col    (rom_col),
        .rom_color  (rom_color),
        .rgb_out    (rgb_out),
        .sprite_on  (sprite_on)
    );

    always #5 clk = ~clk;

    // Sprite content: one transparent pixel, one black pixel, otherwise distinct non-key colours.
    function automatic logic [11:0] rom_fn(int r, int c);
        logic [3:0] rr;
        logic [4:0] cc;
        rr = 4'(r);
        cc = 5'(c);
        if (r == 1 && c == 2) return 12'hFFF;
        if (r == 2 && c == 3) return 12'h000;
        return {rr + 4'h1, 3'b101, cc};
    endfunction

    // Synchronous ROM: data for the address seen at an edge appears after that edge.
    always @(posedge clk) rom_color <= rom_fn(int'(rom_row), int'(rom_col));

    always @(posedge clk) cyc <= cyc + 1;

    // Output side of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            checks++;
            assert (rgb_out === e.rgb) else begin
                errors++;
                $error("FAIL rgb_out cyc=%0d got=%h exp=%h", cyc, rgb_out, e.rgb);
            end
            checks++;
            assert (sprite_on === e.son) else begin
                errors++;
                $error("FAIL sprite_on cyc=%0d got=%b exp=%b", cyc, sprite_on, e.son);
            end
        end
    end

    task automatic drive(int xi, int yi, bit von, bit pl, int px, int py, bit ft);
        bit   inb;
        int   er, ec;
        exp_t e;
        logic [11:0] rc, bg;
        @(negedge clk);
        reset      = 1'b0;
        x          = 10'(xi);
        y          = 10'(yi);
        video_on   = von;
        pos_load   = pl;
        pos_x      = 10'(px);
        pos_y      = 10'(py);
        frame_tick = ft;
        bg         = 12'(xi * 3 + yi * 5 + 1);
        bg_rgb     = bg;
        inb = von && xi >= m_cx && xi < m_cx + 128 && yi >= m_cy && yi < m_cy + 64;
        er  = inb ? (yi - m_cy) / 4 : 0;
        ec  = inb ? (xi - m_cx) / 4 : 0;
        #1;
        checks++;
        assert (rom_row === 10'(er)) else begin
            errors++;
            $error("FAIL rom_row x=%0d y=%0d got=%0d exp=%0d", xi, yi, rom_row, er);
        end
        checks++;
        assert (rom_col === 10'(ec)) else begin
            errors++;
            $error("FAIL rom_col x=%0d y=%0d got=%0d exp=%0d", xi, yi, rom_col, ec);
        end
        rc = rom_fn(er, ec);
        e.due = cyc + 2;
        if (!von) begin
            e.rgb = 12'h000; e.son = 1'b0;
        end else if (inb && rc != 12'hFFF) begin
            e.rgb = rc;      e.son = 1'b1;
        end else begin
            e.rgb = bg;      e.son = 1'b0;
        end
        q.push_back(e);
        if (pl) begin
            m_px = px; m_py = py; m_pv = 1'b1;
        end else if (ft && m_pv) begin
            m_cx = m_px; m_cy = m_py; m_pv = 1'b0;
        end
    endtask

    task automatic pix(int xi, int yi);
        drive(xi, yi, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic check_zero_outputs(string tag);
        checks++;
        assert (rgb_out === 12'h000) else begin
            errors++;
            $error("FAIL %s rgb_out got=%h exp=000", tag, rgb_out);
        end
        checks++;
        assert (sprite_on === 1'b0) else begin
            errors++;
            $error("FAIL %s sprite_on got=%b exp=0", tag, sprite_on);
        end
    endtask

    initial begin
        reset = 1'b1; video_on = 1'b0; x = '0; y = '0; frame_tick = 1'b0;
        pos_load = 1'b0; pos_x = '0; pos_y = '0; bg_rgb = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");

        // Origin, magnification boundaries, clipping of box edges.
        pix(256, 200);
        pix(259, 203);
        pix(260, 203);
        pix(383, 200);
        pix(384, 200);
        pix(255, 200);
        pix(300, 263);
        pix(300, 264);
        pix(300, 199);
        // Transparent and black ROM pixels.
        pix(264, 204);
        pix(268, 208);
        // Blanking inside the box.
        drive(270, 210, 1'b0, 1'b0, 0, 0, 1'b0);

        // Mid-frame load keeps the old position until frame_tick.
        drive(0, 0, 1'b1, 1'b1, 600, 470, 1'b0);
        pix(256, 200);
        pix(600, 470);
        drive(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        // Frame scan after moving to the lower-right corner.
        for (int yy = 0; yy < 480; yy += 6)
            for (int xx = 0; xx < 640; xx += 8)
                pix(xx, yy);
        pix(600, 470); pix(639, 479); pix(599, 470); pix(600, 469);
        pix(0, 0); pix(127, 63); pix(40, 9);

        // Last of two loads wins.
        drive(0, 0, 1'b0, 1'b1, 10, 10, 1'b0);
        drive(0, 0, 1'b0, 1'b1, 20, 20, 1'b0);
        drive(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        pix(20, 20); pix(19, 20); pix(10, 10); pix(147, 83); pix(148, 83);

        // Load coinciding with frame_tick waits for the next tick.
        drive(0, 0, 1'b0, 1'b1, 100, 100, 1'b1);
        pix(20, 20); pix(100, 100);
        drive(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        pix(100, 100); pix(20, 20);

        // Reset in the middle of a frame.
        pix(110, 110);
        pix(111, 111);
        @(negedge clk);
        reset = 1'b1; video_on = 1'b1; x = 10'd112; y = 10'd112;
        q.delete();
        @(negedge clk);
        check_zero_outputs("midreset");
        m_cx = 256; m_cy = 200; m_px = 256; m_py = 200; m_pv = 1'b0;
        pix(256, 200);
        pix(112, 112);
        pix(300, 230);

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
